// File: rtl/branch_cond_unit_if.sv
// Branch request/result bundle between the control unit (master) and branch_cond_unit (slave).
// BRANCH_LINK_EN adds the link request bit and the link register result.
interface branch_cond_unit_if #(
    parameter int ADDR_W = 12,
    parameter int COND_W = 4
);
    logic              br_start;
    logic [COND_W-1:0] cond;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_in;
    logic              N;
    logic              Z;
    logic              C;
    logic              V;
    logic              br_busy;
    logic              taken;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;
    logic              br_done;
`ifdef BRANCH_LINK_EN
    logic              link;
    logic [ADDR_W-1:0] lr;

    modport master (
        output br_start, cond, target, pc_in, N, Z, C, V, link,
        input  br_busy, taken, pc_load, pc_next, br_done, lr
    );
    modport slave (
        input  br_start, cond, target, pc_in, N, Z, C, V, link,
        output br_busy, taken, pc_load, pc_next, br_done, lr
    );
`else
    modport master (
        output br_start, cond, target, pc_in, N, Z, C, V,
        input  br_busy, taken, pc_load, pc_next, br_done
    );
    modport slave (
        input  br_start, cond, target, pc_in, N, Z, C, V,
        output br_busy, taken, pc_load, pc_next, br_done
    );
`endif
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: snapshots NZCV/operands on br_start, evaluates cond, loads next PC.
// Latency: br_start in cycle 0 -> pc_load/br_done in cycle 2; next request accepted from cycle 3.
// No backpressure: br_start while busy is dropped. BRANCH_LINK_EN adds link/lr.
module branch_cond_unit #(
    parameter int ADDR_W = 12,
    parameter int COND_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_cond_unit_if.slave bif
);
    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

    state_t            state, state_nxt;
    logic [COND_W-1:0] cond_q;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        nzcv_q;
    logic              taken_r;
    logic [ADDR_W-1:0] pc_next_r;
    logic [ADDR_W-1:0] pc_inc;
    logic              cond_true;
    logic              accept;

    // Truncation to ADDR_W gives the wrap from all-ones to zero.
    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign accept = (state == IDLE) && bif.br_start;

    function automatic logic cond_hold(input logic [COND_W-1:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:    cond_hold = 1'b1;
            4'd1:    cond_hold = z;
            4'd2:    cond_hold = !z;
            4'd3:    cond_hold = cf;
            4'd4:    cond_hold = !cf;
            4'd5:    cond_hold = n;
            4'd6:    cond_hold = !n;
            4'd7:    cond_hold = v;
            4'd8:    cond_hold = !v;
            4'd9:    cond_hold = cf & !z;
            4'd10:   cond_hold = !cf | z;
            4'd11:   cond_hold = (n == v);
            4'd12:   cond_hold = (n != v);
            4'd13:   cond_hold = !z & (n == v);
            4'd14:   cond_hold = z | (n != v);
            default: cond_hold = 1'b0;
        endcase
    endfunction

    assign cond_true = cond_hold(cond_q, nzcv_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bif.br_busy  = 1'b1;
        bif.pc_load  = 1'b0;
        bif.br_done  = 1'b0;
        unique case (state)
            IDLE: begin
                bif.br_busy = 1'b0;
                if (bif.br_start) state_nxt = EVAL;
            end
            EVAL:   state_nxt = COMMIT;
            COMMIT: begin
                bif.pc_load = 1'b1;
                bif.br_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q   <= '0;
            target_q <= '0;
            pc_q     <= '0;
            nzcv_q   <= '0;
        end else if (accept) begin
            cond_q   <= bif.cond;
            target_q <= bif.target;
            pc_q     <= bif.pc_in;
            nzcv_q   <= {bif.N, bif.Z, bif.C, bif.V};
        end
    end

    // Result registers load at the end of EVAL so pc_next/taken are already valid while pc_load is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_r   <= 1'b0;
            pc_next_r <= '0;
        end else if (state == EVAL) begin
            taken_r   <= cond_true;
            pc_next_r <= cond_true ? target_q : pc_inc;
        end
    end

    assign bif.taken   = taken_r;
    assign bif.pc_next = pc_next_r;

`ifdef BRANCH_LINK_EN
    logic              link_q;
    logic [ADDR_W-1:0] lr_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      link_q <= 1'b0;
        else if (accept) link_q <= bif.link;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  lr_r <= '0;
        else if (state == COMMIT && link_q && taken_r) lr_r <= pc_inc;
    end

    assign bif.lr = lr_r;
`endif
endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit with a scoreboard of expected {taken, pc_next} per request.
module tb_branch_cond_unit;
    localparam int ADDR_W = 12;

    typedef struct {
        logic              taken;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   loads  = 0;
    exp_t sb[$];
    logic [ADDR_W-1:0] lr_model = '0;

    branch_cond_unit_if #(.ADDR_W(ADDR_W), .COND_W(4)) bif ();

    branch_cond_unit #(.ADDR_W(ADDR_W), .COND_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return 1'b1;
            4'h1: return z == 1'b1;
            4'h2: return z == 1'b0;
            4'h3: return cf == 1'b1;
            4'h4: return cf == 1'b0;
            4'h5: return n == 1'b1;
            4'h6: return n == 1'b0;
            4'h7: return v == 1'b1;
            4'h8: return v == 1'b0;
            4'h9: return (cf == 1'b1) && (z == 1'b0);
            4'hA: return (cf == 1'b0) || (z == 1'b1);
            4'hB: return (n ^ v) == 1'b0;
            4'hC: return (n ^ v) == 1'b1;
            4'hD: return (z == 1'b0) && ((n ^ v) == 1'b0);
            4'hE: return (z == 1'b1) || ((n ^ v) == 1'b1);
            default: return 1'b0;
        endcase
    endfunction

    // Every pc_load must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bif.pc_load) begin
            exp_t e;
            loads++;
            if (sb.size() == 0) begin
                chk("unexpected_load_queue", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("sb_taken", bif.taken, e.taken);
                chk("sb_pc_next", bif.pc_next, e.pc);
                chk("sb_br_done", bif.br_done, 1);
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [3:0] f, input logic [ADDR_W-1:0] pc,
                         input logic [ADDR_W-1:0] tgt, input logic lk);
        bif.cond   = c;
        {bif.N, bif.Z, bif.C, bif.V} = f;
        bif.pc_in  = pc;
        bif.target = tgt;
`ifdef BRANCH_LINK_EN
        bif.link   = lk;
`else
        if (lk) bif.br_start = 1'b1;
`endif
        bif.br_start = 1'b1;
    endtask

    task automatic expect_push(input logic [3:0] c, input logic [3:0] f, input logic [ADDR_W-1:0] pc,
                               input logic [ADDR_W-1:0] tgt, input logic lk);
        exp_t e;
        logic [ADDR_W-1:0] ft;
        ft      = pc + 12'd1;
        e.taken = ref_cond(c, f);
        e.pc    = e.taken ? tgt : ft;
        sb.push_back(e);
        if (lk && e.taken) lr_model = ft;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 8 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic run_branch(input logic [3:0] c, input logic [3:0] f, input logic [ADDR_W-1:0] pc,
                              input logic [ADDR_W-1:0] tgt, input logic lk, input string tag);
        @(posedge clk); #1;
        drive(c, f, pc, tgt, lk);
        expect_push(c, f, pc, tgt, lk);
        @(posedge clk); #1;
        bif.br_start = 1'b0;
        wait_drain(tag);
    endtask

    initial begin
        int loads0;
        rst_n = 1'b0;
        bif.br_start = 1'b0;
        bif.cond = '0; bif.target = '0; bif.pc_in = '0;
        bif.N = 1'b0; bif.Z = 1'b0; bif.C = 1'b0; bif.V = 1'b0;
`ifdef BRANCH_LINK_EN
        bif.link = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_br_busy", bif.br_busy, 0);
            chk("idle_pc_load", bif.pc_load, 0);
            chk("idle_pc_next", bif.pc_next, 12'h000);
            chk("idle_taken", bif.taken, 0);
        end
`ifdef BRANCH_LINK_EN
        chk("idle_lr", bif.lr, 12'h000);
`endif

        // EQ taken, cycle-accurate latency
        @(posedge clk); #1;
        drive(4'd1, 4'b0100, 12'h010, 12'h200, 1'b0);
        expect_push(4'd1, 4'b0100, 12'h010, 12'h200, 1'b0);
        @(negedge clk);
        chk("eq_c0_busy", bif.br_busy, 0);
        chk("eq_c0_load", bif.pc_load, 0);
        @(posedge clk); #1 bif.br_start = 1'b0;
        @(negedge clk);
        chk("eq_c1_busy", bif.br_busy, 1);
        chk("eq_c1_load", bif.pc_load, 0);
        @(negedge clk);
        chk("eq_c2_load", bif.pc_load, 1);
        chk("eq_c2_done", bif.br_done, 1);
        chk("eq_c2_taken", bif.taken, 1);
        chk("eq_c2_pc_next", bif.pc_next, 12'h200);
        @(negedge clk);
        chk("eq_c3_load", bif.pc_load, 0);
        chk("eq_c3_done", bif.br_done, 0);
        chk("eq_c3_busy", bif.br_busy, 0);
        chk("eq_c3_pc_hold", bif.pc_next, 12'h200);
        chk("eq_sb_empty", sb.size(), 0);

        // LT not taken with fall-through wrap
        run_branch(4'd12, 4'b1001, 12'hFFF, 12'h040, 1'b0, "lt_wrap_drain");
        chk("lt_taken", bif.taken, 0);
        chk("lt_pc_wrap", bif.pc_next, 12'h000);

        // GE: flags flip and second br_start while busy must be ignored
        loads0 = loads;
        @(posedge clk); #1;
        drive(4'd11, 4'b0000, 12'h0AA, 12'h321, 1'b0);
        expect_push(4'd11, 4'b0000, 12'h0AA, 12'h321, 1'b0);
        @(posedge clk); #1;
        drive(4'd15, 4'b1000, 12'h555, 12'h777, 1'b0);
        @(posedge clk); #1 bif.br_start = 1'b0;
        wait_drain("ge_drain");
        repeat (4) @(negedge clk);
        chk("ge_taken", bif.taken, 1);
        chk("ge_pc_next", bif.pc_next, 12'h321);
        chk("ge_one_load", loads - loads0, 1);

        // Full cond x NZCV sweep
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                run_branch(4'(c), 4'(f), 12'(16 * c + f), 12'(12'h800 + 16 * f + c), 1'b0, "sweep_drain");
                chk("sweep_taken", bif.taken, ref_cond(4'(c), 4'(f)));
            end
        end

        // Reset asserted during EVAL aborts the branch
        @(posedge clk); #1;
        drive(4'd0, 4'b0000, 12'h100, 12'h3AB, 1'b0);
        @(posedge clk); #1 bif.br_start = 1'b0;
        loads0 = loads;
        chk("rst_pre_busy", bif.br_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", bif.br_busy, 0);
        chk("rst_load", bif.pc_load, 0);
        chk("rst_done", bif.br_done, 0);
        chk("rst_pc_next", bif.pc_next, 12'h000);
        chk("rst_taken", bif.taken, 0);
        repeat (3) @(negedge clk);
        chk("rst_no_load", loads - loads0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        lr_model = '0;
        repeat (3) @(negedge clk);
        chk("rst_after_no_load", loads - loads0, 0);
        run_branch(4'd2, 4'b0000, 12'h0F0, 12'h0BC, 1'b0, "post_rst_drain");
        chk("post_rst_pc", bif.pc_next, 12'h0BC);

`ifdef BRANCH_LINK_EN
        run_branch(4'd0, 4'b0000, 12'h123, 12'h456, 1'b1, "link_al_drain");
        @(negedge clk);
        chk("link_al_lr", bif.lr, lr_model);
        chk("link_al_lr_val", bif.lr, 12'h124);
        run_branch(4'd15, 4'b1111, 12'h300, 12'h456, 1'b1, "link_nv_drain");
        @(negedge clk);
        chk("link_nv_lr_hold", bif.lr, 12'h124);
        run_branch(4'd0, 4'b0000, 12'hFFF, 12'h010, 1'b0, "nolink_drain");
        @(negedge clk);
        chk("nolink_lr_hold", bif.lr, 12'h124);
        run_branch(4'd0, 4'b0000, 12'hFFF, 12'h010, 1'b1, "link_wrap_drain");
        @(negedge clk);
        chk("link_wrap_lr", bif.lr, 12'h000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
